// File: rtl/pll_clkdiv_multi_if.sv
// rtl/pll_clkdiv_multi_if.sv - configuration and output bundle for pll_clkdiv_multi
//
// Signals:
//   BYPASS           all enables forced high, CLKOUT free-toggles
//   UPDATE           one-cycle pulse: recapture DIVQ/PHASE and relock
//   DIVQ             per-channel divide field, period = DIVQ+1 cycles
//   PHASE            per-channel initial count offset
//   LATCHINPUTVALUE  freeze request for channels enabled in ENABLE_ICEGATE
//   CLKEN            one-cycle enable per divided period
//   CLKOUT           registered square wave, period 2*(DIVQ+1)
//   LOCK             dividers running with the captured configuration
interface pll_clkdiv_multi_if #(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = 8
);
  logic                    BYPASS;
  logic                    UPDATE;
  logic [NUM_CH*DIV_W-1:0] DIVQ;
  logic [NUM_CH*DIV_W-1:0] PHASE;
  logic                    LATCHINPUTVALUE;
  logic [NUM_CH-1:0]       CLKEN;
  logic [NUM_CH-1:0]       CLKOUT;
  logic                    LOCK;

  modport master (
    output BYPASS, UPDATE, DIVQ, PHASE, LATCHINPUTVALUE,
    input  CLKEN, CLKOUT, LOCK
  );

  modport slave (
    input  BYPASS, UPDATE, DIVQ, PHASE, LATCHINPUTVALUE,
    output CLKEN, CLKOUT, LOCK
  );
endinterface

// File: rtl/pll_clkdiv_multi.sv
// rtl/pll_clkdiv_multi.sv - multi-channel clock-enable divider with lock sequencer
//
// Ports:
//   REFERENCECLK  sole clock, rising edge
//   RESETB        asynchronous active-low reset
//   bus           pll_clkdiv_multi_if slave: BYPASS, UPDATE, DIVQ, PHASE,
//                 LATCHINPUTVALUE in; CLKEN, CLKOUT, LOCK out
module pll_clkdiv_multi #(
  parameter int                NUM_CH         = 2,
  parameter int                DIV_W          = 8,
  parameter int                LOCK_CYCLES    = 16,
  parameter logic [NUM_CH-1:0] ENABLE_ICEGATE = {NUM_CH{1'b0}}
) (
  input  logic                  REFERENCECLK,
  input  logic                  RESETB,
  pll_clkdiv_multi_if.slave     bus
);

  localparam int LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RESET   = 2'd0,
    ST_LOCKING = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [LCW-1:0]          lock_cnt;
  logic [NUM_CH*DIV_W-1:0] div_sh;
  logic [NUM_CH*DIV_W-1:0] ph_sh;
  logic                    lock_q;
  logic                    btog;
  logic                    capture;
  logic                    lock_done;
  logic                    run;
  logic [NUM_CH-1:0]       clken_q;
  logic [NUM_CH-1:0]       clkout_q;

  // Next-state logic. UPDATE during LOCKING takes priority over lock completion
  // so a relock always starts a full LOCK_CYCLES window.
  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    lock_done = 1'b0;
    run       = 1'b0;
    case (state_q)
      ST_RESET: begin
        state_d = ST_LOCKING;
        capture = 1'b1;
      end
      ST_LOCKING: begin
        if (bus.UPDATE) begin
          capture = 1'b1;
        end else if (lock_cnt == LOCK_LAST) begin
          state_d   = ST_LOCKED;
          lock_done = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (bus.UPDATE) begin
          state_d = ST_LOCKING;
          capture = 1'b1;
        end else begin
          run = 1'b1;
        end
      end
      default: state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge REFERENCECLK or negedge RESETB) begin
    if (!RESETB) begin
      state_q  <= ST_RESET;
      lock_cnt <= '0;
      div_sh   <= '0;
      ph_sh    <= '0;
      lock_q   <= 1'b0;
      btog     <= 1'b0;
    end else begin
      state_q <= state_d;
      lock_q  <= (state_d == ST_LOCKED);
      btog    <= ~btog;
      if (capture) begin
        div_sh   <= bus.DIVQ;
        ph_sh    <= bus.PHASE;
        lock_cnt <= '0;
      end else if (state_q == ST_LOCKING && !lock_done) begin
        lock_cnt <= lock_cnt + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_i;
    logic [DIV_W-1:0] ph_i;
    logic [DIV_W-1:0] start;
    logic             frozen;
    logic             clken_r;
    logic             clkout_r;

    assign div_i  = div_sh[i*DIV_W +: DIV_W];
    assign ph_i   = ph_sh[i*DIV_W +: DIV_W];
    // Offsets beyond the period are clipped so cnt never exceeds div and
    // the wrap compare always fires.
    assign start  = (ph_i > div_i) ? div_i : ph_i;
    assign frozen = ENABLE_ICEGATE[i] & bus.LATCHINPUTVALUE;

    always_ff @(posedge REFERENCECLK or negedge RESETB) begin
      if (!RESETB) begin
        cnt      <= '0;
        clken_r  <= 1'b0;
        clkout_r <= 1'b0;
      end else if (lock_done) begin
        cnt      <= start;
        clken_r  <= 1'b0;
        clkout_r <= 1'b0;
      end else if (run) begin
        if (frozen) begin
          clken_r <= 1'b0;
        end else if (cnt == div_i) begin
          cnt      <= '0;
          clken_r  <= 1'b1;
          clkout_r <= ~clkout_r;
        end else begin
          cnt     <= cnt + 1'b1;
          clken_r <= 1'b0;
        end
      end else begin
        clken_r  <= 1'b0;
        clkout_r <= 1'b0;
      end
    end

    assign clken_q[i]  = clken_r;
    assign clkout_q[i] = clkout_r;
  end

  // Bypass is a pure output override; the sequencer keeps running underneath
  // so releasing it shows the live divided outputs immediately.
  logic bypass_act;
  assign bypass_act = bus.BYPASS && (state_q != ST_RESET);

  assign bus.CLKEN  = bypass_act ? {NUM_CH{1'b1}} :
                      ((state_q == ST_LOCKED) ? clken_q : '0);
  assign bus.CLKOUT = bypass_act ? {NUM_CH{btog}} :
                      ((state_q == ST_LOCKED) ? clkout_q : '0);
  assign bus.LOCK   = lock_q;

endmodule

// File: tb/tb_pll_clkdiv_multi.sv
// tb/tb_pll_clkdiv_multi.sv - directed self-checking bench for pll_clkdiv_multi
module tb_pll_clkdiv_multi;

  logic clk = 1'b0;
  logic rstn;
  int   n_pass  = 0;
  int   n_total = 0;
  int   e       = 0;

  always #5 clk = ~clk;

  pll_clkdiv_multi_if #(.NUM_CH(2), .DIV_W(8)) bus ();

  pll_clkdiv_multi #(
    .NUM_CH(2),
    .DIV_W(8),
    .LOCK_CYCLES(16),
    .ENABLE_ICEGATE(2'b01)
  ) dut (
    .REFERENCECLK(clk),
    .RESETB(rstn),
    .bus(bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic chk(input string tag, input logic [4:0] expv);
    logic [4:0] obs;
    obs = {bus.LOCK, bus.CLKOUT, bus.CLKEN};
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed {lock,clkout,clken}=%b expected %b", tag, obs, expv);
  endtask

  // Expected CLKEN per edge for the main scenario, from hand timing:
  // ch0 DIVQ3/PH0 then DIVQ1 after relock (frozen 55..59), ch1 DIVQ3 PH2 then PH9.
  function automatic logic [1:0] pulses(input int k);
    logic p0, p1;
    p1 = (((k >= 19) && (k <= 29)) || (k >= 47)) && (k % 4 == 3);
    p0 = ((k >= 21) && (k <= 29) && (k % 4 == 1)) ||
         ((k >= 47) && (k <= 54) && (k % 2 == 0)) ||
         ((k >= 61) && (k % 2 == 1));
    return {p1, p0};
  endfunction

  initial begin
    logic [1:0] co;
    logic [1:0] p;
    logic [4:0] expv;

    rstn                = 1'b0;
    bus.BYPASS          = 1'b0;
    bus.UPDATE          = 1'b0;
    bus.LATCHINPUTVALUE = 1'b0;
    bus.DIVQ            = {8'd3, 8'd3};
    bus.PHASE           = {8'd2, 8'd0};
    #12;
    chk("reset_state", 5'b0_00_00);

    @(posedge clk);
    #1;
    rstn = 1'b1;
    e    = 0;
    for (int k = 1; k <= 17; k++) begin
      step();
      chk($sformatf("lockwait_edge%0d", k), {(k == 17), 4'b0000});
    end

    co = 2'b00;
    for (int k = 18; k <= 70; k++) begin
      step();
      p = pulses(k);
      if (k == 30) co = 2'b00;
      else         co = co ^ p;
      if (k >= 64 && k <= 66)
        expv = {1'b1, {2{(k % 2 == 1)}}, 2'b11};
      else
        expv = {!((k >= 30) && (k <= 45)), co, p};
      chk($sformatf("run_edge%0d", k), expv);

      if (k == 27) begin
        // New settings must not matter until UPDATE
        bus.DIVQ  = {8'd3, 8'd1};
        bus.PHASE = {8'd9, 8'd0};
      end
      if (k == 29) bus.UPDATE = 1'b1;
      if (k == 30) bus.UPDATE = 1'b0;
      if (k == 54) bus.LATCHINPUTVALUE = 1'b1;
      if (k == 59) bus.LATCHINPUTVALUE = 1'b0;
      if (k == 63) begin
        bus.BYPASS = 1'b1;
        #1;
        chk("bypass_on_comb", 5'b1_11_11);
      end
      if (k == 66) begin
        bus.BYPASS = 1'b0;
        #1;
        chk("bypass_release_comb", {1'b1, co, p});
      end
    end

    // Asynchronous reset between edges, with UPDATE and BYPASS held high
    #3;
    rstn       = 1'b0;
    bus.UPDATE = 1'b1;
    bus.BYPASS = 1'b1;
    #1;
    chk("async_reset_immediate", 5'b0_00_00);
    step();
    step();
    chk("reset_held_bypass_ignored", 5'b0_00_00);
    bus.UPDATE = 1'b0;
    rstn       = 1'b1;
    #1;
    chk("reset_release_state_reset", 5'b0_00_00);

    for (int k = 1; k <= 17; k++) begin
      step();
      chk($sformatf("bypass_lock_edge%0d", k), {(k == 17), {2{(k % 2 == 1)}}, 2'b11});
    end
    bus.BYPASS = 1'b0;
    #1;
    chk("bypass_release_locked", 5'b1_00_00);
    step();
    chk("clip_ch1_first_pulse", 5'b1_10_10);
    step();
    chk("ch0_div1_first_pulse", 5'b1_11_01);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
